// File: rtl/lsu_hs_mmio.sv
// Purpose : MEM-stage load/store unit: byte-banked data RAM plus output and input MMIO regions.
// Latency : request accepted at edge E0, response registered at E1, rsp_valid_o high after E1.
// Backpres: one request in flight; req_ready_o low until the response is taken by rsp_ready_i.
//
// Ports
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   req_valid_i / req_ready_o      request handshake; req_we_i, req_funct3_i, req_addr_i, req_wdata_i
//   rsp_valid_o / rsp_ready_i      response handshake; rsp_rdata_o (extended load data), rsp_err_o
//   io_sw_i, io_btn_i              asynchronous switch / button inputs
//   io_ledr_o, io_hex_o, io_lcd_o  output MMIO registers
//
// Address map (addr[17:16]): 01 data RAM, 10 output MMIO, 11 input MMIO, 00 unmapped.
module lsu_hs_mmio #(
    parameter int DMEM_AW      = 14,
    parameter int N_HEX        = 6,
    parameter int N_BTN        = 4,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [2:0]         req_funct3_i,
    input  logic [31:0]        req_addr_i,
    input  logic [31:0]        req_wdata_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [31:0]        rsp_rdata_o,
    output logic               rsp_err_o,
    input  logic [31:0]        io_sw_i,
    input  logic [N_BTN-1:0]   io_btn_i,
    output logic [31:0]        io_ledr_o,
    output logic [7*N_HEX-1:0] io_hex_o,
    output logic [31:0]        io_lcd_o
);

    localparam int DMEM_DEPTH = 1 << DMEM_AW;
    localparam int CNT_W      = $clog2(DEBOUNCE_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_accept;

    // Latched request. Only addr[17:0] is ever decoded, so the rest is not stored.
    logic        r_we;
    logic [2:0]  r_f3;
    logic [17:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic [31:0] r_ledr;
    logic [31:0] r_lcd;
    logic [6:0]  r_hex [N_HEX];

    logic [31:0]      r_sw_s1, r_sw_s2;
    logic [N_BTN-1:0] r_btn_s1, r_btn_s2;
    logic [N_BTN-1:0] r_btn_db;
    logic [N_BTN-1:0] r_press;
    logic [CNT_W-1:0] r_db_cnt [N_BTN];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                w_accept    = req_valid_i;
                if (req_valid_i) w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_f3    <= 3'd0;
            r_addr  <= 18'd0;
            r_wdata <= 32'd0;
        end else if (w_accept) begin
            r_we    <= req_we_i;
            r_f3    <= req_funct3_i;
            r_addr  <= req_addr_i[17:0];
            r_wdata <= req_wdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the latched request (valid during ACCESS)
    // ------------------------------------------------------------------
    logic [1:0]  w_region;
    logic [5:0]  w_word_off;
    logic        w_misal;
    logic [3:0]  w_be;
    logic [31:0] w_bmask;
    logic [31:0] w_wdata_sh;

    assign w_region   = r_addr[17:16];
    assign w_word_off = r_addr[7:2];

    // funct3[1:0]=11 has no legal size and is reported as misaligned.
    assign w_misal = (r_f3[1:0] == 2'b11)
                   | ((r_f3[1:0] == 2'b01) & r_addr[0])
                   | ((r_f3[1:0] == 2'b10) & (r_addr[1:0] != 2'b00));

    always_comb begin
        w_be = 4'b0000;
        case (r_f3[1:0])
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_bmask    = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_wdata_sh = r_wdata << {r_addr[1:0], 3'b000};

    // Output region decode and read mux
    logic        w_hit_ledr, w_hit_lcd, w_hit_hex;
    logic [31:0] w_out_rd;

    assign w_hit_ledr = (w_word_off == 6'h00);
    assign w_hit_lcd  = (w_word_off == 6'h10);

    always_comb begin
        w_hit_hex = 1'b0;
        w_out_rd  = 32'd0;
        if (w_hit_ledr) w_out_rd = r_ledr;
        if (w_hit_lcd)  w_out_rd = r_lcd;
        for (int i = 0; i < N_HEX; i++) begin
            if (w_word_off == 6'(4 + i)) begin
                w_hit_hex = 1'b1;
                w_out_rd  = {25'd0, r_hex[i]};
            end
        end
    end

    // Input region decode and read mux
    logic        w_hit_sw, w_hit_btn, w_hit_press;
    logic [31:0] w_in_rd;

    assign w_hit_sw    = (w_word_off == 6'h00);
    assign w_hit_btn   = (w_word_off == 6'h01);
    assign w_hit_press = (w_word_off == 6'h02);

    always_comb begin
        w_in_rd = 32'd0;
        if (w_hit_sw)    w_in_rd = r_sw_s2;
        if (w_hit_btn)   w_in_rd = 32'(r_btn_db);
        if (w_hit_press) w_in_rd = 32'(r_press);
    end

    // Error: misalignment, unmapped region, unknown offset, or a store to a read-only input.
    logic w_dec_err, w_err;

    always_comb begin
        w_dec_err = 1'b1;
        case (w_region)
            2'b01:   w_dec_err = 1'b0;
            2'b10:   w_dec_err = ~(w_hit_ledr | w_hit_lcd | w_hit_hex);
            2'b11:   w_dec_err = ~(w_hit_sw | w_hit_btn | w_hit_press) | (r_we & ~w_hit_press);
            default: w_dec_err = 1'b1;
        endcase
    end

    assign w_err = w_misal | w_dec_err;

    // Side effects happen only on the ACCESS->RESP edge; a reset that lands first
    // forces IDLE and cancels them.
    logic w_commit, w_ram_we, w_out_we, w_in_we;

    assign w_commit = (r_state == S_ACCESS) & r_we & ~w_err;
    assign w_ram_we = w_commit & (w_region == 2'b01);
    assign w_out_we = w_commit & (w_region == 2'b10);
    assign w_in_we  = w_commit & (w_region == 2'b11);

    // ------------------------------------------------------------------
    // Data RAM: four byte banks, read issued on the accept edge so the
    // word is available during ACCESS.
    // ------------------------------------------------------------------
    logic [DMEM_AW-1:0] w_rd_idx, w_wr_idx;
    logic [31:0]        w_ram_rdata;

    assign w_rd_idx = req_addr_i[DMEM_AW+1:2];
    assign w_wr_idx = r_addr[DMEM_AW+1:2];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] r_bank [DMEM_DEPTH];
        logic [7:0] r_rd_byte;

        always_ff @(posedge clk_i) begin
            if (w_ram_we && w_be[b]) r_bank[w_wr_idx] <= w_wdata_sh[8*b +: 8];
            if (w_accept)            r_rd_byte        <= r_bank[w_rd_idx];
        end

        assign w_ram_rdata[8*b +: 8] = r_rd_byte;
    end

    // ------------------------------------------------------------------
    // Load formatting and response register
    // ------------------------------------------------------------------
    logic [31:0] w_ld_word, w_ld_sh, w_ld_ext, w_rsp_rdata;

    always_comb begin
        w_ld_word = 32'd0;
        case (w_region)
            2'b01:   w_ld_word = w_ram_rdata;
            2'b10:   w_ld_word = w_out_rd;
            2'b11:   w_ld_word = w_in_rd;
            default: w_ld_word = 32'd0;
        endcase
    end

    assign w_ld_sh = w_ld_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_ld_ext = w_ld_sh;
        case (r_f3[1:0])
            2'b00:   w_ld_ext = {{24{w_ld_sh[7]  & ~r_f3[2]}}, w_ld_sh[7:0]};
            2'b01:   w_ld_ext = {{16{w_ld_sh[15] & ~r_f3[2]}}, w_ld_sh[15:0]};
            default: w_ld_ext = w_ld_sh;
        endcase
    end

    assign w_rsp_rdata = (w_err | r_we) ? 32'd0 : w_ld_ext;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else if (r_state == S_ACCESS) begin
            r_rsp_rdata <= w_rsp_rdata;
            r_rsp_err   <= w_err;
        end
    end

    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

    // ------------------------------------------------------------------
    // Output registers: sub-word stores merge into the current word.
    // ------------------------------------------------------------------
    logic [31:0] w_merged;

    assign w_merged = (w_out_rd & ~w_bmask) | (w_wdata_sh & w_bmask);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ledr <= 32'd0;
            r_lcd  <= 32'd0;
            for (int i = 0; i < N_HEX; i++) r_hex[i] <= 7'd0;
        end else if (w_out_we) begin
            if (w_hit_ledr) r_ledr <= w_merged;
            if (w_hit_lcd)  r_lcd  <= w_merged;
            for (int i = 0; i < N_HEX; i++) begin
                if (w_word_off == 6'(4 + i)) r_hex[i] <= w_merged[6:0];
            end
        end
    end

    assign io_ledr_o = r_ledr;
    assign io_lcd_o  = r_lcd;

    for (genvar i = 0; i < N_HEX; i++) begin : g_hex
        assign io_hex_o[7*i +: 7] = r_hex[i];
    end

    // ------------------------------------------------------------------
    // Input synchronisers, debounce and sticky press register
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] w_db_flip, w_db_rise, w_press_clr;
    logic [31:0]      w_clr_bits;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            w_db_flip[i] = (r_btn_s2[i] != r_btn_db[i]) &&
                           (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYC - 1));
        end
    end

    assign w_db_rise   = w_db_flip & r_btn_s2;
    assign w_clr_bits  = w_wdata_sh & w_bmask;
    assign w_press_clr = w_in_we ? w_clr_bits[N_BTN-1:0] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sw_s1  <= 32'd0;
            r_sw_s2  <= 32'd0;
            r_btn_s1 <= '0;
            r_btn_s2 <= '0;
            r_btn_db <= '0;
            r_press  <= '0;
            for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
        end else begin
            r_sw_s1  <= io_sw_i;
            r_sw_s2  <= r_sw_s1;
            r_btn_s1 <= io_btn_i;
            r_btn_s2 <= r_btn_s1;
            // Counter only runs while the synchronised level disagrees with the
            // debounced one; any return to agreement restarts the count.
            for (int i = 0; i < N_BTN; i++) begin
                if (r_btn_s2[i] == r_btn_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (w_db_flip[i]) begin
                    r_btn_db[i] <= r_btn_s2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
            // A new press wins over a simultaneous clear.
            r_press <= (r_press & ~w_press_clr) | w_db_rise;
        end
    end

    // Address bits outside the decoded map and the cleared-lane bits above the
    // button field are intentionally ignored.
    logic w_unused;
    assign w_unused = ^{req_addr_i[31:18], w_clr_bits[31:N_BTN]};

endmodule

// File: tb/tb_lsu_hs_mmio.sv
module tb_lsu_hs_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid_o;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] io_sw = 32'hCAFE_F00D;
    logic [3:0]  io_btn = 4'd0;
    logic [31:0] io_ledr_o;
    logic [41:0] io_hex_o;
    logic [31:0] io_lcd_o;

    always #5 clk = ~clk;

    lsu_hs_mmio #(.DMEM_AW(14), .N_HEX(6), .N_BTN(4), .DEBOUNCE_CYC(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_we_i(req_we),
        .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .io_sw_i(io_sw), .io_btn_i(io_btn),
        .io_ledr_o(io_ledr_o), .io_hex_o(io_hex_o), .io_lcd_o(io_lcd_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: memory by byte address, MMIO registers as plain values.
    logic [7:0]  mem_m [int];
    logic [31:0] m_ledr = 32'd0, m_lcd = 32'd0, m_sw = 32'hCAFE_F00D;
    logic [6:0]  m_hex [6] = '{default: 7'd0};
    logic [3:0]  m_btn = 4'd0, m_press = 4'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [41:0] hex_exp();
        logic [41:0] h;
        for (int i = 0; i < 6; i++) h[7*i +: 7] = m_hex[i];
        return h;
    endfunction

    // Applies one access to the reference state and returns the expected response.
    task automatic model_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, output logic [31:0] erd, output logic eer);
        int nb, lo, off, hexi, kind, base;
        logic [31:0] word, msk, bm, sh, val;
        nb   = (f3[1:0] == 2'b11) ? 0 : (1 << f3[1:0]);
        lo   = int'(a[1:0]);
        off  = (int'(a[7:0]) / 4) * 4;
        base = int'(a[15:0]);
        kind = 0; hexi = 0; val = 32'd0; word = 32'd0;
        case (a[17:16])
            2'b01: kind = 1;
            2'b10: begin
                if (off == 0) kind = 2;
                else if (off == 'h40) kind = 3;
                else if (off >= 'h10 && off < 'h10 + 4*6) begin kind = 4; hexi = (off - 'h10) / 4; end
            end
            2'b11: begin
                if (off == 0 && !we) kind = 5;
                else if (off == 4 && !we) kind = 6;
                else if (off == 8) kind = 7;
            end
            default: kind = 0;
        endcase
        erd = 32'd0;
        eer = (nb == 0) || (lo % nb != 0) || (kind == 0);
        if (eer) return;
        msk = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nb)) - 1);
        if (kind == 1) begin
            for (int k = 0; k < nb; k++) begin
                if (we) mem_m[base + k] = wd[8*k +: 8];
                else    val[8*k +: 8]   = mem_m[base + k];
            end
        end else begin
            case (kind)
                2: word = m_ledr;
                3: word = m_lcd;
                4: word = {25'd0, m_hex[hexi]};
                5: word = m_sw;
                6: word = {28'd0, m_btn};
                default: word = {28'd0, m_press};
            endcase
            bm = msk << (8*lo);
            sh = wd << (8*lo);
            if (we) begin
                case (kind)
                    2: m_ledr = (word & ~bm) | (sh & bm);
                    3: m_lcd  = (word & ~bm) | (sh & bm);
                    4: begin word = (word & ~bm) | (sh & bm); m_hex[hexi] = word[6:0]; end
                    default: m_press = m_press & ~(sh[3:0] & bm[3:0]);
                endcase
            end else begin
                val = (word >> (8*lo)) & msk;
            end
        end
        if (!we) begin
            if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | ~msk;
            erd = val;
        end
    endtask

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] ard, output logic aer,
                           output logic [31:0] erd, output logic eer);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready_o && w < 10) begin @(negedge clk); w++; end
        if (!req_ready_o) chk("req_ready_timeout", 32'(req_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rsp_valid_in_access", 32'(rsp_valid_o), 32'd0);
        @(negedge clk);
        chk("rsp_valid_after_e1", 32'(rsp_valid_o), 32'd1);
        w = 0;
        while (!rsp_valid_o && w < 10) begin @(negedge clk); w++; end
        ard = rsp_rdata_o;
        aer = rsp_err_o;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        model_txn(we, f3, a, wd, erd, eer);
    endtask

    // Presents a request and returns right after the accepting edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eer;
    } vec_t;

    vec_t tbl [30];

    initial begin
        logic [31:0] ard, erd, v, a, wd;
        logic        aer, eer, we;
        logic [2:0]  f3;
        logic [2:0]  ldf [5];
        int          r;

        tbl[0]  = '{1'b1, 3'd2, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0001_0003, 32'h0,         32'hFFFF_FFDE, 1'b0};
        tbl[2]  = '{1'b0, 3'd4, 32'h0001_0003, 32'h0,         32'h0000_00DE, 1'b0};
        tbl[3]  = '{1'b0, 3'd1, 32'h0001_0002, 32'h0,         32'hFFFF_DEAD, 1'b0};
        tbl[4]  = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[5]  = '{1'b1, 3'd1, 32'h0001_0001, 32'h0000_1111, 32'h0000_0000, 1'b1};
        tbl[6]  = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[7]  = '{1'b0, 3'd2, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b1};
        tbl[8]  = '{1'b0, 3'd5, 32'h0001_0000, 32'h0,         32'h0000_BEEF, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 32'h0001_0000, 32'h0,         32'hFFFF_FFEF, 1'b0};
        tbl[10] = '{1'b1, 3'd0, 32'h0001_0001, 32'h0000_0055, 32'h0000_0000, 1'b0};
        tbl[11] = '{1'b0, 3'd2, 32'h0001_0000, 32'h0,         32'hDEAD_55EF, 1'b0};
        tbl[12] = '{1'b0, 3'd3, 32'h0001_0000, 32'h0,         32'h0000_0000, 1'b1};
        tbl[13] = '{1'b1, 3'd0, 32'h0002_0014, 32'h0000_007F, 32'h0000_0000, 1'b0};
        tbl[14] = '{1'b0, 3'd2, 32'h0002_0014, 32'h0,         32'h0000_007F, 1'b0};
        tbl[15] = '{1'b1, 3'd2, 32'h0002_0000, 32'h0000_00A5, 32'h0000_0000, 1'b0};
        tbl[16] = '{1'b0, 3'd2, 32'h0002_0000, 32'h0,         32'h0000_00A5, 1'b0};
        tbl[17] = '{1'b0, 3'd2, 32'h0002_0044, 32'h0,         32'h0000_0000, 1'b1};
        tbl[18] = '{1'b0, 3'd2, 32'h0002_0028, 32'h0,         32'h0000_0000, 1'b1};
        tbl[19] = '{1'b1, 3'd2, 32'h0003_0000, 32'h1234_5678, 32'h0000_0000, 1'b1};
        tbl[20] = '{1'b1, 3'd1, 32'h0002_0042, 32'h0000_1234, 32'h0000_0000, 1'b0};
        tbl[21] = '{1'b0, 3'd2, 32'h0002_0040, 32'h0,         32'h1234_0000, 1'b0};
        tbl[22] = '{1'b1, 3'd2, 32'h0002_0018, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        tbl[23] = '{1'b0, 3'd0, 32'h0002_0018, 32'h0,         32'h0000_007F, 1'b0};
        tbl[24] = '{1'b1, 3'd0, 32'h0002_0001, 32'h0000_00C3, 32'h0000_0000, 1'b0};
        tbl[25] = '{1'b0, 3'd2, 32'h0002_0000, 32'h0,         32'h0000_C3A5, 1'b0};
        tbl[26] = '{1'b0, 3'd1, 32'h0002_0001, 32'h0,         32'h0000_0000, 1'b1};
        tbl[27] = '{1'b0, 3'd2, 32'h0003_0004, 32'h0,         32'h0000_0000, 1'b0};
        tbl[28] = '{1'b0, 3'd2, 32'h0003_0000, 32'h0,         32'hCAFE_F00D, 1'b0};
        tbl[29] = '{1'b0, 3'd0, 32'h0003_0003, 32'h0,         32'hFFFF_FFCA, 1'b0};

        ldf[0] = 3'd0; ldf[1] = 3'd1; ldf[2] = 3'd2; ldf[3] = 3'd4; ldf[4] = 3'd5;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_o), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_rsp_err",   32'(rsp_err_o),   32'd0);
        chk("rst_rsp_rdata", rsp_rdata_o,      32'd0);
        chk("rst_ledr",      io_ledr_o,        32'd0);
        chk("rst_hex",       32'(io_hex_o[31:0]), 32'd0);
        chk("rst_lcd",       io_lcd_o,         32'd0);

        // Directed table
        for (int i = 0; i < 30; i++) begin
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, ard, aer, erd, eer);
            chk($sformatf("tbl%0d_rdata", i), ard, tbl[i].erd);
            chk($sformatf("tbl%0d_err", i), 32'(aer), 32'(tbl[i].eer));
        end
        chk("hex1_after_sb", 32'(io_hex_o[13:7]),  32'h7F);
        chk("hex2_after_sw", 32'(io_hex_o[20:14]), 32'h7F);
        chk("ledr_after_merge", io_ledr_o, 32'h0000_C3A5);
        chk("lcd_after_sh",     io_lcd_o,  32'h1234_0000);

        // Response backpressure: held response must not move
        issue(1'b0, 3'd2, 32'h0002_0000, 32'd0);
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_valid", i), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("bp%0d_rdata", i), rsp_rdata_o, 32'h0000_C3A5);
            chk($sformatf("bp%0d_ready", i), 32'(req_ready_o), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_release_valid", 32'(rsp_valid_o), 32'd0);
        chk("bp_release_ready", 32'(req_ready_o), 32'd1);

        // Debounce: short pulses are filtered
        for (int p = 0; p < 3; p++) begin
            io_btn[0] = 1'b1; repeat (8) @(negedge clk);
            io_btn[0] = 1'b0; repeat (4) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        run_txn(1'b0, 3'd2, 32'h0003_0004, 32'd0, ard, aer, erd, eer);
        chk("glitch_btn", ard, 32'd0);
        run_txn(1'b0, 3'd2, 32'h0003_0008, 32'd0, ard, aer, erd, eer);
        chk("glitch_press", ard, 32'd0);

        // Long hold is accepted and latches a press
        @(negedge clk); io_btn[0] = 1'b1;
        repeat (20) @(negedge clk);
        m_btn = 4'd1; m_press = 4'd1;
        run_txn(1'b0, 3'd2, 32'h0003_0004, 32'd0, ard, aer, erd, eer);
        chk("hold_btn", ard, 32'd1);
        run_txn(1'b0, 3'd2, 32'h0003_0008, 32'd0, ard, aer, erd, eer);
        chk("hold_press", ard, 32'd1);
        run_txn(1'b1, 3'd0, 32'h0003_0009, 32'h01, ard, aer, erd, eer);
        chk("w1c_wrong_lane_err", 32'(aer), 32'd0);
        run_txn(1'b0, 3'd2, 32'h0003_0008, 32'd0, ard, aer, erd, eer);
        chk("w1c_wrong_lane_keep", ard, 32'd1);
        run_txn(1'b1, 3'd0, 32'h0003_0008, 32'h01, ard, aer, erd, eer);
        chk("w1c_err", 32'(aer), 32'd0);
        run_txn(1'b0, 3'd2, 32'h0003_0008, 32'd0, ard, aer, erd, eer);
        chk("w1c_cleared", ard, 32'd0);
        run_txn(1'b0, 3'd2, 32'h0003_0004, 32'd0, ard, aer, erd, eer);
        chk("btn_still_held", ard, 32'd1);
        io_btn[0] = 1'b0;
        repeat (25) @(negedge clk);
        m_btn = 4'd0;
        run_txn(1'b0, 3'd2, 32'h0003_0004, 32'd0, ard, aer, erd, eer);
        chk("release_btn", ard, 32'd0);
        run_txn(1'b0, 3'd2, 32'h0003_0008, 32'd0, ard, aer, erd, eer);
        chk("release_no_press", ard, 32'd0);

        // Random traffic against the reference model
        for (int j = 0; j < 8; j++) begin
            run_txn(1'b1, 3'd2, 32'h0001_0100 + 32'(4*j), $urandom, ard, aer, erd, eer);
        end
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                @(negedge clk);
                io_sw = $urandom;
                m_sw  = io_sw;
                repeat (3) @(negedge clk);
            end
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 2)) : ldf[$urandom_range(0, 4)];
            if ($urandom_range(0, 15) == 0) f3 = 3'd3;
            a  = $urandom;
            wd = $urandom;
            r  = $urandom_range(0, 9);
            if (r == 0)      a[17:16] = 2'b00;
            else if (r < 5)  begin a[17:16] = 2'b01; a[15:0] = 16'h0100 + 16'($urandom_range(0, 31)); end
            else if (r < 8)  begin a[17:16] = 2'b10; a[7:0] = 8'($urandom_range(0, 17) * 4 + $urandom_range(0, 3)); end
            else             begin a[17:16] = 2'b11; a[7:0] = 8'($urandom_range(0, 15)); end
            run_txn(we, f3, a, wd, ard, aer, erd, eer);
            chk($sformatf("rnd%0d_rdata a=%h f3=%0d we=%0d", i, a, f3, we), ard, erd);
            chk($sformatf("rnd%0d_err", i), 32'(aer), 32'(eer));
            chk($sformatf("rnd%0d_ledr", i), io_ledr_o, m_ledr);
            chk($sformatf("rnd%0d_lcd", i), io_lcd_o, m_lcd);
            chk($sformatf("rnd%0d_hex", i), 32'(io_hex_o[31:0]), 32'(hex_exp()));
        end

        // Reset during ACCESS of a RAM store: store is dropped
        run_txn(1'b0, 3'd2, 32'h0001_0100, 32'd0, ard, aer, erd, eer);
        chk("pre_rst_load", ard, erd);
        v = erd;
        issue(1'b1, 3'd2, 32'h0001_0100, ~v);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(rsp_valid_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid_after", 32'(rsp_valid_o), 32'd0);
        m_ledr = 32'd0; m_lcd = 32'd0; m_press = 4'd0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'd0;
        run_txn(1'b0, 3'd2, 32'h0001_0100, 32'd0, ard, aer, erd, eer);
        chk("rst_store_dropped", ard, v);

        // Reset during ACCESS of a LEDR store
        issue(1'b1, 3'd2, 32'h0002_0000, 32'h0000_00A5);
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ledr_kept_zero", io_ledr_o, 32'd0);
        chk("rst_ledr_no_rsp", 32'(rsp_valid_o), 32'd0);
        run_txn(1'b0, 3'd2, 32'h0002_0000, 32'd0, ard, aer, erd, eer);
        chk("rst_ledr_readback", ard, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1);
    end

endmodule
